// File: rtl/vga_avalon_pkg.sv
// Shared types for the Avalon pixel/rectangle-fill engine: command word, register map, FSM states.
package vga_avalon_pkg;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 8;

    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [X_W-1:0]      w;
        logic [Y_W-1:0]      h;
        logic [COLOUR_W-1:0] colour;
    } cmd_t;

    localparam logic [3:0] ADDR_PLOT    = 4'd0;
    localparam logic [3:0] ADDR_ORIGIN  = 4'd1;
    localparam logic [3:0] ADDR_FILL    = 4'd2;
    localparam logic [3:0] ADDR_STATUS  = 4'd3;
    localparam logic [3:0] ADDR_CLIPCNT = 4'd4;

    typedef enum logic {
        IDLE,
        DRAW
    } state_t;

endpackage

// File: rtl/vga_cmd_fifo.sv
// Synchronous FIFO of draw commands with registered full flag and level count.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored.
module vga_cmd_fifo
    import vga_avalon_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  cmd_t          push_dat,
    input  logic          pop,
    output cmd_t          pop_dat,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_nxt;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_comb begin
        level_nxt = level + LW'(push_ok) - LW'(pop_ok);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            level <= level_nxt;
            full  <= (level_nxt == LW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/vga_avalon_fill.sv
// Avalon-MM slave queueing plot/fill commands and streaming one pixel per clock to vga_adapter.
// Latency: PLOT accepted in cycle N drives pix_plot in N+2; readdata valid the cycle after read.
// Backpressure: waitrequest stalls PLOT/FILL writes while the FIFO is full. Option: VGA_AVALON_FILL_CLIPCNT_EN.
module vga_avalon_fill
    import vga_avalon_pkg::*;
#(
    parameter int H_RES      = 160,
    parameter int V_RES      = 120,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [3:0]          address,
    input  logic                read,
    output logic [31:0]         readdata,
    input  logic                write,
    input  logic [31:0]         writedata,
    output logic                waitrequest,
    output logic [X_W-1:0]      pix_x,
    output logic [Y_W-1:0]      pix_y,
    output logic [COLOUR_W-1:0] pix_colour,
    output logic                pix_plot
);

    localparam int           LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [X_W:0] H_LIM = (X_W+1)'(H_RES);
    localparam logic [Y_W:0] V_LIM = (Y_W+1)'(V_RES);

    cmd_t             push_cmd;
    cmd_t             head;
    cmd_t             cur_q;
    logic             push_addr;
    logic             push;
    logic             pop;
    logic             load;
    logic             emit;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_level;
    logic [X_W-1:0]   x0_q;
    logic [Y_W-1:0]   y0_q;
    state_t           state_q;
    state_t           state_nxt;
    logic [X_W:0]     cx_q;
    logic [X_W:0]     nx;
    logic [X_W:0]     x_end;
    logic [Y_W:0]     cy_q;
    logic [Y_W:0]     ny;
    logic [Y_W:0]     y_end;
    logic [COLOUR_W-1:0] emit_colour;
    logic             nxt_vis;
    logic             row_end;
    logic             last_pix;
    logic             busy;
    logic [31:0]      clip_cnt;
    logic [31:0]      rd_mux;
    logic             unused_wd;

    assign unused_wd   = &{1'b0, writedata[31], writedata[15]};
    assign push_addr   = (address == ADDR_PLOT) || (address == ADDR_FILL);
    assign waitrequest = write && push_addr && fifo_full;
    assign push        = write && push_addr && !fifo_full;

    always_comb begin
        push_cmd.y      = writedata[30:24];
        push_cmd.x      = writedata[23:16];
        push_cmd.w      = X_W'(1);
        push_cmd.h      = Y_W'(1);
        push_cmd.colour = writedata[7:0];
        if (address == ADDR_FILL) begin
            push_cmd.x = x0_q;
            push_cmd.y = y0_q;
            push_cmd.w = writedata[23:16];
            push_cmd.h = writedata[14:8];
        end
    end

    vga_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push),
        .push_dat (push_cmd),
        .pop      (pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    // Extents are one bit wider than the fields so x+w-1 never wraps.
    assign x_end    = {1'b0, cur_q.x} + {1'b0, cur_q.w} - 1'b1;
    assign y_end    = {1'b0, cur_q.y} + {1'b0, cur_q.h} - 1'b1;
    assign row_end  = (cx_q == x_end);
    assign last_pix = row_end && (cy_q == y_end);
    assign busy     = !fifo_empty || (state_q != IDLE);

    // The pixel registers load the coordinate the FSM moves to, so each DRAW cycle shows its own pixel.
    always_comb begin
        state_nxt   = state_q;
        pop         = 1'b0;
        load        = 1'b0;
        emit        = 1'b0;
        nx          = cx_q;
        ny          = cy_q;
        emit_colour = cur_q.colour;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if ((head.w != '0) && (head.h != '0)) begin
                        load        = 1'b1;
                        emit        = 1'b1;
                        state_nxt   = DRAW;
                        nx          = {1'b0, head.x};
                        ny          = {1'b0, head.y};
                        emit_colour = head.colour;
                    end
                end
            end
            DRAW: begin
                if (last_pix) begin
                    state_nxt = IDLE;
                end else begin
                    emit = 1'b1;
                    if (row_end) begin
                        nx = {1'b0, cur_q.x};
                        ny = cy_q + 1'b1;
                    end else begin
                        nx = cx_q + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        nxt_vis = (nx < H_LIM) && (ny < V_LIM);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cur_q      <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            pix_plot   <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_colour <= '0;
        end else begin
            state_q  <= state_nxt;
            cx_q     <= nx;
            cy_q     <= ny;
            pix_plot <= emit && nxt_vis;
            if (load) cur_q <= head;
            if (emit && nxt_vis) begin
                pix_x      <= nx[X_W-1:0];
                pix_y      <= ny[Y_W-1:0];
                pix_colour <= emit_colour;
            end
        end
    end

`ifdef VGA_AVALON_FILL_CLIPCNT_EN
    logic        clip_now;
    logic [31:0] clip_cnt_q;

    assign clip_now = (state_q == DRAW) && !((cx_q < H_LIM) && (cy_q < V_LIM));
    assign clip_cnt = clip_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clip_cnt_q <= '0;
        end else if (write && (address == ADDR_CLIPCNT)) begin
            clip_cnt_q <= '0;
        end else if (clip_now && (clip_cnt_q != '1)) begin
            clip_cnt_q <= clip_cnt_q + 1'b1;
        end
    end
`else
    assign clip_cnt = '0;
`endif

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_STATUS:  rd_mux = {16'h0, 8'(fifo_level), 7'h0, busy};
            ADDR_CLIPCNT: rd_mux = clip_cnt;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x0_q     <= '0;
            y0_q     <= '0;
            readdata <= '0;
        end else begin
            if (write && (address == ADDR_ORIGIN)) begin
                x0_q <= writedata[23:16];
                y0_q <= writedata[30:24];
            end
            readdata <= read ? rd_mux : '0;
        end
    end

endmodule

// File: tb/tb_vga_avalon_fill.sv
// Randomised and directed bench for vga_avalon_fill against a loop-based pixel model.
module tb_vga_avalon_fill;

    logic        clk;
    logic        reset_n;
    logic [3:0]  address;
    logic        read;
    logic [31:0] readdata;
    logic        write;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [7:0]  pix_x;
    logic [6:0]  pix_y;
    logic [7:0]  pix_colour;
    logic        pix_plot;

    vga_avalon_fill dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .address     (address),
        .read        (read),
        .readdata    (readdata),
        .write       (write),
        .writedata   (writedata),
        .waitrequest (waitrequest),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_colour  (pix_colour),
        .pix_plot    (pix_plot)
    );

    typedef struct {
        int         cyc;
        logic [7:0] x;
        logic [6:0] y;
        logic [7:0] c;
    } pix_t;

    pix_t        got_q[$];
    logic [22:0] exp_q[$];
    int          exp_clip;
    int          mx0;
    int          my0;
    int          cyc;
    int          acc_cyc;
    int          last_stall;
    int          n_checks;
    int          n_errs;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        pix_t p;
        if (reset_n === 1'b1 && pix_plot === 1'b1) begin
            p.cyc = cyc;
            p.x   = pix_x;
            p.y   = pix_y;
            p.c   = pix_colour;
            got_q.push_back(p);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wd(input int x, input int y, input int h, input int c);
        logic [7:0] xv;
        logic [6:0] yv;
        logic [6:0] hv;
        logic [7:0] cv;
        xv = x[7:0];
        yv = y[6:0];
        hv = h[6:0];
        cv = c[7:0];
        return {1'b0, yv, xv, 1'b0, hv, cv};
    endfunction

    // Reference: every command expands to its full rectangle, clipped against 160x120.
    task automatic model_cmd(input int x, input int y, input int w, input int h, input int c);
        int px;
        int py;
        for (int j = 0; j < h; j++) begin
            for (int i = 0; i < w; i++) begin
                px = x + i;
                py = y + j;
                if (px < 160 && py < 120) exp_q.push_back({px[7:0], py[6:0], c[7:0]});
                else exp_clip++;
            end
        end
    endtask

    task automatic model_write(input logic [3:0] a, input logic [31:0] d);
        case (a)
            4'd0: model_cmd(int'(d[23:16]), int'(d[30:24]), 1, 1, int'(d[7:0]));
            4'd1: begin
                mx0 = int'(d[23:16]);
                my0 = int'(d[30:24]);
            end
            4'd2: model_cmd(mx0, my0, int'(d[23:16]), int'(d[14:8]), int'(d[7:0]));
            4'd4: exp_clip = 0;
            default: ;
        endcase
    endtask

    function automatic logic [31:0] clip_expect();
`ifdef VGA_AVALON_FILL_CLIPCNT_EN
        return exp_clip;
`else
        return 32'd0;
`endif
    endfunction

    task automatic av_write(input logic [3:0] a, input logic [31:0] d);
        int n;
        n = 0;
        @(negedge clk);
        address   = a;
        writedata = d;
        write     = 1'b1;
        #1;
        while (waitrequest && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        last_stall = n;
        if (n >= 2000) chk("write_timeout", 1, 0);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        write   = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        model_write(a, d);
        av_write(a, d);
    endtask

    task automatic av_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        read    = 1'b1;
        @(posedge clk);
        #1;
        read = 1'b0;
        d    = readdata;
    endtask

    task automatic wait_idle();
        logic [31:0] s;
        int          n;
        n = 0;
        s = 32'hffff_ffff;
        while (s[15:0] != 16'h0 && n < 4000) begin
            av_read(4'd3, s);
            n++;
        end
        if (n >= 4000) chk("idle_timeout", 0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic cmp_stream(input string tag);
        int n;
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk({tag, "_pix"}, {got_q[i].x, got_q[i].y, got_q[i].c}, exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_clip(input string tag);
        logic [31:0] r;
        av_read(4'd4, r);
        chk(tag, r, clip_expect());
    endtask

    initial begin
        logic [31:0] r;
        int          t0;
        n_checks  = 0;
        n_errs    = 0;
        exp_clip  = 0;
        mx0       = 0;
        my0       = 0;
        reset_n   = 1'b0;
        address   = 4'd0;
        read      = 1'b0;
        write     = 1'b1;
        writedata = 32'h1414_00ff;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pix_plot", pix_plot, 0);
        chk("rst_pix_xyc", {pix_x, pix_y, pix_colour}, 0);
        chk("rst_readdata", readdata, 0);
        chk("rst_waitrequest", waitrequest, 0);
        write = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        av_read(4'd3, r);
        chk("rst_status", r, 0);

        // 1: single plot, exact latency
        got_q.delete();
        wr(4'd0, 32'h1414_00ff);
        t0 = acc_cyc;
        wait_idle();
        chk("plot_count", got_q.size(), 1);
        if (got_q.size() > 0) chk("plot_latency", got_q[0].cyc, t0 + 1);
        cmp_stream("plot");

        // 2: fully clipped plot
        wr(4'd0, wd(200, 5, 0, 8'h33));
        wait_idle();
        cmp_stream("clip_plot");
        av_read(4'd3, r);
        chk("clip_status", r, 0);
        chk_clip("clip_cnt1");

        // 3: 3x2 fill, consecutive pixels
        wr(4'd1, wd(5, 5, 0, 0));
        wr(4'd2, wd(3, 0, 2, 8'h80));
        wait_idle();
        if (got_q.size() == 6) chk("fill_span", got_q[5].cyc - got_q[0].cyc, 5);
        else chk("fill_span_n", got_q.size(), 6);
        cmp_stream("fill3x2");

        // 4: fill over the corner, then a plot to time the spent cycles
        wr(4'd1, wd(158, 119, 0, 0));
        wr(4'd2, wd(4, 0, 2, 8'h1c));
        wr(4'd0, wd(1, 2, 0, 8'h44));
        wait_idle();
        if (got_q.size() == 3) chk("corner_cycles", got_q[2].cyc - got_q[0].cyc, 9);
        else chk("corner_n", got_q.size(), 3);
        cmp_stream("corner");
        chk_clip("clip_cnt7");
        wr(4'd4, 32'h0);
        chk_clip("clip_clear");

        // 5: FIFO full back-pressure behind a long fill
        wr(4'd1, wd(10, 10, 0, 0));
        wr(4'd2, wd(10, 0, 10, 8'h07));
        for (int i = 0; i < 5; i++) begin
            wr(4'd0, wd($urandom_range(0, 159), $urandom_range(0, 119), 0, $urandom_range(0, 255)));
            if (i < 4) chk("no_stall", last_stall, 0);
            else chk("fifth_stalls", (last_stall > 90 && last_stall < 110), 1);
        end
        av_read(4'd3, r);
        chk("status_full", r, 32'h0000_0401);
        wait_idle();
        cmp_stream("backpressure");
        wr(4'd2, wd(0, 0, 5, 8'h11));
        wait_idle();
        cmp_stream("zero_width");

        // 6: reset in the middle of a fill
        wr(4'd1, wd(0, 0, 0, 0));
        wr(4'd2, wd(50, 0, 50, 8'h99));
        repeat (20) @(negedge clk);
        chk("pre_reset_plot", pix_plot, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("async_reset_plot", pix_plot, 0);
        chk("async_reset_xy", {pix_x, pix_y}, 0);
        mx0      = 0;
        my0      = 0;
        exp_clip = 0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        got_q.delete();
        repeat (30) @(negedge clk);
        chk("no_residual", got_q.size(), 0);
        av_read(4'd3, r);
        chk("post_reset_status", r, 0);
        chk_clip("post_reset_clip");
        wr(4'd2, wd(1, 0, 1, 8'h5a));
        wait_idle();
        cmp_stream("origin_reset");

        // 7: random command mix
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: wr(4'd1, wd($urandom_range(0, 170), $urandom_range(0, 127), 0, 0));
                3, 4, 5, 6: wr(4'd0, wd($urandom_range(0, 170), $urandom_range(0, 127), 0,
                                       $urandom_range(0, 255)));
                default: wr(4'd2, wd($urandom_range(0, 12), 0, $urandom_range(0, 10),
                                     $urandom_range(0, 255)));
            endcase
        end
        wait_idle();
        cmp_stream("random");
        chk_clip("random_clip");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
